// File: rtl/mem_pkg.sv
// Shared types for the byte-wide memory arbiter: FSM states, requester IDs
// and default bus widths.
package mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU bus (read/write) and the video fetch unit (read only)
// onto a single memory port, sequencing read latency and one-cycle acks.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int VID_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter value in the cycle where mem_rdata is valid.
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_e            state_q, state_d;
    gnt_e              last_q, last_d;
    gnt_e              owner_q, owner_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              grant_vid_s;

    // Two-requester choice: video wins when alone, under fixed priority, or when CPU won last.
    always_comb begin
        if (cpu_req && vid_req) begin
            grant_vid_s = (VID_PRIO == 1) || (last_q == GNT_CPU);
        end else begin
            grant_vid_s = vid_req;
        end
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            ST_IDLE: begin
                lat_d = 2'd0;
                if (grant_vid_s) begin
                    owner_d    = GNT_VID;
                    last_d     = GNT_VID;
                    mem_addr_d = vid_addr;
                    state_d    = ST_READ;
                end else if (cpu_req) begin
                    owner_d    = GNT_CPU;
                    last_d     = GNT_CPU;
                    mem_addr_d = cpu_addr;
                    if (cpu_we) begin
                        // Write strobe and ack go out together in the single WRITE cycle.
                        mem_wdata_d = cpu_wdata;
                        mem_we_d    = 1'b1;
                        cpu_ack_d   = 1'b1;
                        state_d     = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_READ: begin
                if (lat_q == LAT_LAST) begin
                    if (owner_q == GNT_VID) begin
                        vid_rdata_d = mem_rdata;
                        vid_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = ST_ACK;
                end else begin
                    lat_d = (lat_q == 2'd3) ? 2'd3 : lat_q + 2'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_CPU;
            owner_q     <= GNT_CPU;
            lat_q       <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three configurations (RD_LAT 1/2, round-robin and
// video priority) each checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        cpu_req   [NI];
    logic        cpu_we    [NI];
    logic        vid_req   [NI];
    logic        cpu_ack   [NI];
    logic        vid_ack   [NI];
    logic        mem_we    [NI];
    logic [19:0] cpu_addr  [NI];
    logic [19:0] vid_addr  [NI];
    logic [19:0] mem_addr  [NI];
    logic [7:0]  cpu_wdata [NI];
    logic [7:0]  cpu_rdata [NI];
    logic [7:0]  vid_rdata [NI];
    logic [7:0]  mem_wdata [NI];
    logic [7:0]  mem_rdata [NI];

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    always @(posedge clk) tcyc <= tcyc + 1;

    // Power-on memory contents; 0x12345 holds 0x5A.
    function automatic logic [7:0] init_val(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3D;
    endfunction

    function automatic logic [19:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 20'($urandom);
        else return 20'($urandom_range(0, 15));
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0d: got %0h, expected %0h", nm, k, tcyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string nm, input int k);
        checks++;
        errors++;
        $display("FAIL %s inst%0d: no ack within 200 cycles, expected an ack", nm, k);
    endtask

    task automatic cpu_txn(input int k, input logic we, input logic [19:0] a, input logic [7:0] d,
                           input bit keep, output int lat, output int at,
                           output logic mwe, output logic [19:0] maddr, output logic [7:0] mwd);
        cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
        lat = -1; at = -1; mwe = 1'b0; maddr = 20'h0; mwd = 8'h0;
        while (at < 0) begin
            @(negedge clk);
            lat++;
            if (cpu_ack[k] === 1'b1) begin
                at = tcyc; mwe = mem_we[k]; maddr = mem_addr[k]; mwd = mem_wdata[k];
            end else if (lat > 200) begin
                timeout("cpu_timeout", k);
                at = tcyc;
            end
        end
        step();
        if (!keep) cpu_req[k] = 1'b0;
    endtask

    task automatic vid_txn(input int k, input logic [19:0] a, input bit keep, output int lat, output int at);
        vid_req[k] = 1'b1; vid_addr[k] = a;
        lat = -1; at = -1;
        while (at < 0) begin
            @(negedge clk);
            lat++;
            if (vid_ack[k] === 1'b1) begin
                at = tcyc;
            end else if (lat > 200) begin
                timeout("vid_timeout", k);
                at = tcyc;
            end
        end
        step();
        if (!keep) vid_req[k] = 1'b0;
    endtask

    task automatic cpu_rand(input int k);
        int lat, at; bit keep; logic mwe; logic [19:0] ma; logic [7:0] md;
        keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!keep) repeat ($urandom_range(0, 3)) step();
            keep = ($urandom_range(0, 2) == 0);
            cpu_txn(k, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), keep, lat, at, mwe, ma, md);
        end
        cpu_req[k] = 1'b0;
    endtask

    task automatic vid_rand(input int k);
        int lat, at; bit keep;
        keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!keep) repeat ($urandom_range(0, 3)) step();
            keep = ($urandom_range(0, 2) == 0);
            vid_txn(k, rand_addr(), keep, lat, at);
        end
        vid_req[k] = 1'b0;
    endtask

    task automatic run_inst(input int k);
        int lat, lc, lv, at, t0, l, v;
        int va [3];
        int ca [2];
        bit saw;
        logic mwe; logic [19:0] ma; logic [7:0] md;
        l = (k == 1) ? 2 : 1;
        v = (k == 2) ? 1 : 0;
        rst[k] = 1'b1;
        repeat (3) step();
        rst[k] = 1'b0;

        cpu_txn(k, 1'b0, 20'h12345, 8'h00, 1'b0, lat, at, mwe, ma, md);
        chk("rd_ack_cycle", k, 32'(lat), 32'(l + 2));
        chk("rd_data", k, 32'(cpu_rdata[k]), 32'h5A);

        cpu_txn(k, 1'b1, 20'h12345, 8'hA5, 1'b0, lat, at, mwe, ma, md);
        chk("wr_ack_cycle", k, 32'(lat), 32'd1);
        chk("wr_mem_we", k, 32'(mwe), 32'd1);
        chk("wr_mem_addr", k, 32'(ma), 32'h12345);
        chk("wr_mem_wdata", k, 32'(md), 32'hA5);
        @(negedge clk);
        chk("wr_idle_we", k, 32'(mem_we[k]), 32'd0);
        step();

        cpu_txn(k, 1'b0, 20'h12345, 8'h00, 1'b0, lat, at, mwe, ma, md);
        chk("rdback_data", k, 32'(cpu_rdata[k]), 32'hA5);

        cpu_txn(k, 1'b1, 20'h00000, 8'h11, 1'b1, lat, at, mwe, ma, md);
        t0 = at;
        chk("b2b_lat0", k, 32'(lat), 32'd1);
        chk("b2b_addr0", k, 32'(ma), 32'h00000);
        cpu_txn(k, 1'b1, 20'hFFFFF, 8'h22, 1'b0, lat, at, mwe, ma, md);
        chk("b2b_gap", k, 32'(at - t0), 32'd2);
        chk("b2b_addr1", k, 32'(ma), 32'hFFFFF);
        chk("b2b_wdata1", k, 32'(md), 32'h22);

        if (v == 0) begin
            fork
                begin
                    cpu_txn(k, 1'b0, 20'h00100, 8'h00, 1'b1, lc, ca[0], mwe, ma, md);
                    cpu_txn(k, 1'b0, 20'h00200, 8'h00, 1'b0, lc, ca[1], mwe, ma, md);
                end
                begin
                    vid_txn(k, 20'h00300, 1'b1, lv, va[0]);
                    vid_txn(k, 20'h00400, 1'b0, lv, va[1]);
                end
            join
            chk("rr_vid_then_cpu", k, 32'(ca[0] - va[0]), 32'(l + 3));
            chk("rr_cpu_then_vid", k, 32'(va[1] - ca[0]), 32'(l + 3));
            chk("rr_vid_then_cpu2", k, 32'(ca[1] - va[1]), 32'(l + 3));
            chk("rr_vid_rdata", k, 32'(vid_rdata[k]), 32'h39);
            chk("rr_cpu_rdata", k, 32'(cpu_rdata[k]), 32'h3F);
        end else begin
            fork
                cpu_txn(k, 1'b0, 20'h00500, 8'h00, 1'b0, lc, ca[0], mwe, ma, md);
                begin
                    vid_txn(k, 20'h00600, 1'b1, lv, va[0]);
                    vid_txn(k, 20'h00700, 1'b1, lv, va[1]);
                    vid_txn(k, 20'h00800, 1'b0, lv, va[2]);
                end
            join
            chk("vp_vid_first", k, 32'(ca[0] > va[0]), 32'd1);
            chk("vp_vid_b2b1", k, 32'(va[1] - va[0]), 32'(l + 3));
            chk("vp_vid_b2b2", k, 32'(va[2] - va[1]), 32'(l + 3));
            chk("vp_cpu_after", k, 32'(ca[0] - va[2]), 32'(l + 3));
            chk("vp_cpu_rdata", k, 32'(cpu_rdata[k]), 32'h38);
            chk("vp_vid_rdata", k, 32'(vid_rdata[k]), 32'h35);
        end

        // Reset asserted in cycle 2 of a CPU read.
        cpu_req[k] = 1'b1; cpu_we[k] = 1'b0; cpu_addr[k] = 20'h12345;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin rst[k] = 1'b1; cpu_req[k] = 1'b0; end
            if (c == 3) rst[k] = 1'b0;
            @(negedge clk);
            saw = saw | (cpu_ack[k] === 1'b1);
            if (c == 3) begin
                chk("rst_mem_addr", k, 32'(mem_addr[k]), 32'd0);
                chk("rst_mem_we", k, 32'(mem_we[k]), 32'd0);
                chk("rst_mem_wdata", k, 32'(mem_wdata[k]), 32'd0);
                chk("rst_cpu_rdata", k, 32'(cpu_rdata[k]), 32'd0);
                chk("rst_vid_rdata", k, 32'(vid_rdata[k]), 32'd0);
            end
            step();
        end
        chk("rst_no_ack", k, 32'(saw), 32'd0);
        vid_txn(k, 20'h00100, 1'b0, lat, at);
        chk("post_rst_lat", k, 32'(lat), 32'(l + 2));
        chk("post_rst_data", k, 32'(vid_rdata[k]), 32'h3C);

        fork
            cpu_rand(k);
            vid_rand(k);
        join
        repeat (8) step();
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 1) ? 2 : 1;
        localparam int V = (g == 2) ? 1 : 0;

        mem_arbiter #(.ADDR_W(20), .DATA_W(8), .RD_LAT(L), .VID_PRIO(V)) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .vid_req   (vid_req[g]),
            .vid_addr  (vid_addr[g]),
            .vid_rdata (vid_rdata[g]),
            .vid_ack   (vid_ack[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_we    (mem_we[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Memory controller: data for the address of cycle k appears in cycle k+L.
        logic [7:0] emem [int];
        logic [7:0] p1 = 8'h00;
        logic [7:0] p2 = 8'h00;
        assign mem_rdata[g] = (L == 2) ? p2 : p1;
        initial forever begin
            @(posedge clk);
            p2 <= p1;
            p1 <= emem.exists(int'(mem_addr[g])) ? emem[int'(mem_addr[g])] : init_val(mem_addr[g]);
            if (mem_we[g] === 1'b1) emem[int'(mem_addr[g])] = mem_wdata[g];
        end

        // Transaction-level reference: a grant occupies 2 cycles (write) or L+3 (read).
        int cyc = 0, busy_until = -1, ack_cycle = -1;
        bit started = 1'b0, ack_cpu = 1'b0, ack_rd = 1'b0, last_vid = 1'b0, pick_vid = 1'b0;
        logic [7:0] pend = 8'h00;
        logic [7:0] mmem [int];
        logic e_cack = 1'b0, e_vack = 1'b0, e_we = 1'b0;
        logic [19:0] e_addr = 20'h0;
        logic [7:0] e_wd = 8'h0, e_cr = 8'h0, e_vr = 8'h0;
        initial forever begin
            @(posedge clk);
            if (rst[g] === 1'b1) begin
                busy_until = cyc; ack_cycle = -1; last_vid = 1'b0;
                e_we = 1'b0; e_addr = 20'h0; e_wd = 8'h0; e_cr = 8'h0; e_vr = 8'h0;
            end else begin
                e_we = 1'b0;
                if (cyc > busy_until && (cpu_req[g] || vid_req[g])) begin
                    pick_vid = vid_req[g] && (!cpu_req[g] || V == 1 || !last_vid);
                    last_vid = pick_vid;
                    ack_cpu  = !pick_vid;
                    e_addr   = pick_vid ? vid_addr[g] : cpu_addr[g];
                    if (!pick_vid && cpu_we[g]) begin
                        e_wd = cpu_wdata[g]; e_we = 1'b1;
                        mmem[int'(e_addr)] = e_wd;
                        ack_rd = 1'b0; busy_until = cyc + 1;
                    end else begin
                        pend = mmem.exists(int'(e_addr)) ? mmem[int'(e_addr)] : init_val(e_addr);
                        ack_rd = 1'b1; busy_until = cyc + L + 2;
                    end
                    ack_cycle = busy_until;
                end
            end
            e_cack = (cyc + 1 == ack_cycle) && ack_cpu;
            e_vack = (cyc + 1 == ack_cycle) && !ack_cpu;
            if (ack_rd && e_cack) e_cr = pend;
            if (ack_rd && e_vack) e_vr = pend;
            cyc++;
            started = 1'b1;
        end

        initial forever begin
            @(negedge clk);
            if (started) begin
                chk("cpu_ack", g, 32'(cpu_ack[g]), 32'(e_cack));
                chk("vid_ack", g, 32'(vid_ack[g]), 32'(e_vack));
                chk("ack_exclusive", g, 32'(cpu_ack[g] & vid_ack[g]), 32'd0);
                chk("mem_we", g, 32'(mem_we[g]), 32'(e_we));
                chk("mem_addr", g, 32'(mem_addr[g]), 32'(e_addr));
                chk("mem_wdata", g, 32'(mem_wdata[g]), 32'(e_wd));
                chk("cpu_rdata", g, 32'(cpu_rdata[g]), 32'(e_cr));
                chk("vid_rdata", g, 32'(vid_rdata[g]), 32'(e_vr));
            end
        end
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; vid_req[k] = 1'b0;
            cpu_addr[k] = 20'h0; vid_addr[k] = 20'h0; cpu_wdata[k] = 8'h0;
        end
        step();
        for (int k = 0; k < NI; k++) run_inst(k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide on-chip memory between two requesters.
- Requester 1 is the x8086 CPU bus, which reads and writes.
- Requester 2 is the video/text-mode fetch unit, which only reads.
- Sits between both requesters and the memory controller's CPU-side port; sequences each access, including read latency, and returns one-cycle acks.

Parameters:
ADDR_W, 20, address width (1 MB space)
DATA_W, 8, data width
RD_LAT, 1, cycles from registered address to valid mem_rdata (legal 1..2)
VID_PRIO, 0, 0 = round-robin; 1 = video fixed priority

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU request; held with addr/we/wdata until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid in cpu_ack cycle, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
vid_req  in  1  video read request; held with vid_addr until vid_ack
vid_addr  in  ADDR_W  video address
vid_rdata  out  DATA_W  video read data, valid in vid_ack cycle, held until next video read completes
vid_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  registered address to memory controller
mem_wdata  out  DATA_W  registered write data
mem_we  out  1  registered write strobe
mem_rdata  in  DATA_W  read data from memory controller

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, all outputs 0, last_grant = CPU.
- Reset mid-transaction aborts the transaction with no ack. If mem_we was already high in the reset cycle, that write still lands; mem_we is 0 from the next cycle.
- States: IDLE, WRITE, READ, ACK.
- IDLE with no request: stay in IDLE, mem_we = 0, mem_addr and mem_wdata hold their last values.
- IDLE with one request: grant that requester.
- IDLE with both requests:
  - VID_PRIO = 1: grant video.
  - VID_PRIO = 0: grant the requester that was not last_grant.
  - Update last_grant on every grant.
- On grant (edge ending IDLE cycle T): register mem_addr from the winner. A CPU write also registers mem_wdata and sets mem_we = 1. Next state is WRITE for a CPU write, otherwise READ.
- WRITE (cycle T+1):
  - mem_we = 1 and cpu_ack = 1 in the same cycle; the write commits.
  - Next state IDLE, with mem_we cleared.
  - Write occupancy: 2 cycles.
- READ:
  - Latency counter runs RD_LAT + 1 cycles (T+1 .. T+RD_LAT+1); mem_rdata is valid in the last of these.
  - At the edge ending that cycle, capture mem_rdata into the winner's rdata register and go to ACK.
- ACK (cycle T+RD_LAT+2): assert the winner's ack, then go to IDLE.
  - Read occupancy: RD_LAT + 3 cycles; 4 cycles at RD_LAT = 1.
- Ack handling:
  - The ack cycle is part of the transaction; arbitration never happens in it.
  - A req still high in the IDLE cycle after an ack is a new request.
  - Requesters may drop req, or change addr and keep req, at the ack edge.
- Only the granted requester's ack/rdata change; the other side's rdata holds.
- cpu_ack and vid_ack are never high together.
- Changing addr/we/wdata while req is high and before ack is illegal. The arbiter uses only values registered at grant.
- A req dropped before its ack: the transaction still completes and acks; the requester ignores it.
- Address passes through unmodified; no wrap or arithmetic. The latency counter is 2 bits and saturates.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE, WRITE, READ, ACK), ADDR_W/DATA_W defaults, requester IDs (GNT_CPU, GNT_VID).
- No sub-module: the two-input round-robin choice is inline logic, under 10 lines.

Test Plan:
- CPU write: cpu_req = 1, cpu_we = 1, addr 0x12345, wdata 0xA5 at cycle 0 → mem_we = 1, mem_addr = 0x12345, mem_wdata = 0xA5 and cpu_ack = 1 all in cycle 1. IDLE in cycle 2.
- CPU read, RD_LAT = 1, memory model returns 0x5A for 0x12345: read 0x12345 → cpu_ack in cycle 3 with cpu_rdata = 0x5A. Repeat with RD_LAT = 2 → ack in cycle 4.
- Simultaneous requests, VID_PRIO = 0, both held high for 4 transactions, reset last_grant = CPU → grant order VID, CPU, VID, CPU. vid_rdata holds across CPU transactions. Acks never overlap.
- VID_PRIO = 1, both requesting continuously → video is always granted; cpu_ack never asserts. CPU is granted in the first IDLE after vid_req drops.
- Reset mid-read: rst = 1 in cycle 2 of a CPU read → no cpu_ack. All outputs 0 from cycle 3. A new vid_req after reset completes normally.
- Back-to-back CPU writes to 0x00000 and 0xFFFFF, req held high → acks in cycles 1 and 3, mem_addr correct in each. No write issued in IDLE cycles.
